dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port 8-bit data memory between requester 0 (CPU load/store path) and requester 1 (DMA/loader).
- Each requester gets a request/acknowledge handshake.
- The block drives the memory's MEM_READ, MEM_WRITE, DataAddress and WriteData from registers, and captures the combinational ReadData.
- Arbitration is round-robin, one transaction per grant.

---
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing a single-port data memory between
// requester 0 (CPU load/store) and requester 1 (DMA/loader).
// One transaction per grant, three-cycle cadence: IDLE -> ACCESS -> ACK.
// All outputs are registered. Optional grant statistics are enabled by
// defining DMEM_ARBITER_STATS_EN (adds stats_clr, grant_cnt0, grant_cnt1).
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] DataAddress,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
`ifdef DMEM_ARBITER_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;

  logic                start;
  logic                pick1;

  // Winner selection: a lone requester wins; on contention the port that
  // was not granted last wins.
  always_comb begin
    start = req0 | req1;
    pick1 = req1 & (~req0 | ~last_grant_q);
  end

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata_d      = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          owner_d      = pick1;
          last_grant_d = pick1;
          addr_d       = pick1 ? addr1  : addr0;
          wdata_d      = pick1 ? wdata1 : wdata0;
          mem_write_d  = pick1 ? we1    : we0;
          mem_read_d   = pick1 ? ~we1   : ~we0;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_read_q) begin
          rdata_d = ReadData;
        end
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Arbiter state and registered memory/handshake outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign MEM_READ    = mem_read_q;
  assign MEM_WRITE   = mem_write_q;
  assign DataAddress = addr_q;
  assign WriteData   = wdata_q;

`ifdef DMEM_ARBITER_STATS_EN
  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

  // Saturating grant counters; a clear request overrides a same-cycle grant.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (stats_clr) begin
      grant_cnt0_d = '0;
      grant_cnt1_d = '0;
    end else if ((state_q == ST_IDLE) && start) begin
      if (!pick1 && (grant_cnt0_q != '1)) begin
        grant_cnt0_d = grant_cnt0_q + CNT_W'(1);
      end
      if (pick1 && (grant_cnt1_q != '1)) begin
        grant_cnt1_d = grant_cnt1_q + CNT_W'(1);
      end
    end
  end

  // Grant counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural single-port memory.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_dmem_arbiter;

`ifdef DMEM_ARBITER_STATS_EN
  localparam int unsigned CNT_W = 2;
`else
  localparam int unsigned CNT_W = 16;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       ack0, ack1, busy, MEM_READ, MEM_WRITE;
  logic [7:0] rdata, DataAddress, WriteData, ReadData;
`ifdef DMEM_ARBITER_STATS_EN
  logic             stats_clr = 1'b0;
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  logic [7:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .DataAddress(DataAddress), .WriteData(WriteData), .ReadData(ReadData)
`ifdef DMEM_ARBITER_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 Clk = ~Clk;

  // Behavioural memory: synchronous write, combinational read.
  always @(posedge Clk) begin
    if (MEM_WRITE) mem[DataAddress] <= WriteData;
  end
  assign ReadData = MEM_READ ? mem[DataAddress] : 8'h00;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  // Issue one transaction from an idle arbiter, wait (bounded) for its ack,
  // check latency and which ack fired, then release the request.
  task automatic do_txn(input int port, input logic we, input logic [7:0] a,
                        input logic [7:0] wd, input string tag);
    int  cyc;
    bit  got;
    logic [1:0] seen;
    cyc = 0; got = 0; seen = 2'b00;
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    else           begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    while (!got && cyc < 10) begin
      @(negedge Clk);
      cyc++;
      if (ack0 || ack1) begin got = 1; seen = {ack1, ack0}; end
    end
    check_vec({tag, "_lat"}, cyc, 2);
    check_vec({tag, "_ack"}, {30'd0, seen}, (port == 0) ? 32'd1 : 32'd2);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int wr_cyc, ack_idx, order_idx, cyc;
    bit got;
    logic [1:0] seen;
    logic [1:0] exp_order [4];
    logic [7:0] exp_rd [4];

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h11;
    mem[8'h30] = 8'h22;
    mem[8'hFF] = 8'hC3;

    // Reset values.
    repeat (3) @(negedge Clk);
    check_vec("rst_outs", {ack0, ack1, busy, MEM_READ, MEM_WRITE}, 0);
    check_vec("rst_bus", {rdata, DataAddress, WriteData}, 0);
    Reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check_vec("idle", {ack0, ack1, busy, MEM_READ, MEM_WRITE, rdata, DataAddress, WriteData}, 0);
    end

    // Port 0 write 0x10 = 0xA5, traced cycle by cycle.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
    wr_cyc = 0; ack_idx = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk);
      if (MEM_WRITE) begin
        wr_cyc++;
        check_vec("wr_addr", DataAddress, 8'h10);
        check_vec("wr_data", WriteData, 8'hA5);
        check_vec("wr_busy", busy, 1);
        check_vec("wr_rden", MEM_READ, 0);
      end
      if (ack0 && ack_idx == 0) begin ack_idx = i; req0 = 1'b0; end
    end
    check_vec("wr_cycles", wr_cyc, 1);
    check_vec("wr_ack_idx", ack_idx, 2);
    check_vec("wr_mem", mem[8'h10], 8'hA5);

    // Port 0 read back.
    do_txn(0, 1'b0, 8'h10, 8'h00, "rd10");
    check_vec("rd10_data", rdata, 8'hA5);
    @(negedge Clk);
    check_vec("ack_width", {ack0, ack1}, 0);

    // Contention: both read continuously from a fresh reset (last_grant=1).
    do_reset();
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h11; exp_rd[3] = 8'h22;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h30;
    for (order_idx = 0; order_idx < 4; order_idx++) begin
      cyc = 0; got = 0; seen = 2'b00;
      while (!got && cyc < 10) begin
        @(negedge Clk);
        cyc++;
        if (ack0 || ack1) begin got = 1; seen = {ack1, ack0}; end
      end
      check_vec($sformatf("rr_grant%0d", order_idx), seen, exp_order[order_idx]);
      check_vec($sformatf("rr_rdata%0d", order_idx), rdata, exp_rd[order_idx]);
      check_vec($sformatf("rr_gap%0d", order_idx), cyc, (order_idx == 0) ? 2 : 3);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge Clk);

    // rdata holds across a write.
    do_txn(1, 1'b0, 8'h30, 8'h00, "rd30");
    check_vec("rd30_data", rdata, 8'h22);
    @(negedge Clk);
    do_txn(0, 1'b1, 8'h40, 8'h77, "wr40");
    check_vec("wr40_hold", rdata, 8'h22);
    @(negedge Clk);
    check_vec("wr40_mem", mem[8'h40], 8'h77);
    check_vec("wr40_hold_idle", rdata, 8'h22);

    // Reset during ACCESS aborts port 1 write to 0xFF.
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'hFF; wdata1 = 8'h5A;
    @(negedge Clk);
    check_vec("abort_access", {MEM_WRITE, busy}, 2'b11);
    #1 Reset_n = 1'b0;
    #1;
    check_vec("abort_async", {MEM_WRITE, MEM_READ, busy, ack1}, 0);
    @(negedge Clk);
    req1 = 1'b0;
    check_vec("abort_noack", {ack0, ack1}, 0);
    Reset_n = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check_vec("abort_noack_late", {ack0, ack1}, 0);
    end
    check_vec("abort_mem", mem[8'hFF], 8'hC3);
    do_txn(0, 1'b0, 8'hFF, 8'h00, "rdFF");
    check_vec("rdFF_data", rdata, 8'hC3);
    @(negedge Clk);

`ifdef DMEM_ARBITER_STATS_EN
    // Saturating grant counter with CNT_W=2.
    do_reset();
    check_vec("cnt_rst", {grant_cnt0, grant_cnt1}, 0);
    for (int k = 1; k <= 5; k++) begin
      do_txn(0, 1'b0, 8'h20, 8'h00, "cnt_txn");
      check_vec($sformatf("cnt0_%0d", k), grant_cnt0, (k < 3) ? k : 3);
      @(negedge Clk);
    end
    check_vec("cnt1_zero", grant_cnt1, 0);
    stats_clr = 1'b1;
    @(negedge Clk);
    stats_clr = 1'b0;
    check_vec("cnt_clr", {grant_cnt0, grant_cnt1}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
